mem_arbiter: RTL and testbench

Sequencing controller for the unified word-addressed memory in the multi-cycle CPU. Shares the single memory port between the instruction-fetch requester and the load/store requester, one access at a time. Drives the memory's read/write enables, IorD select, address and write data, and returns captured read data to the granted requester. Adds round-robin fairness, range checking and a contention counter.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Owner encoding doubles as the IorD value driven during an access.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic IORD_INSTR = 1'b0;
  localparam logic IORD_DATA  = 1'b1;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie, the requester not granted last wins.
// Purely combinational; the last-grant history lives in the caller.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  owner_e     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
    end else if (req_i) begin
      gnt = 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and load/store,
// one access at a time (IDLE -> ACCESS -> DONE), with range checking and a contention counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 65,
  parameter int IF_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              mem_iord,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam logic [ADDR_W:0] OFF_EXT   = (ADDR_W+1)'(IF_OFFSET);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [1:0]          gnt;
  logic [ADDR_W:0]     i_sum;
  logic                i_oob, d_oob;
  logic                contend;

  arb_rr2 u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // One extra bit so the fetch offset can never wrap an out-of-range address back in range.
  always_comb begin
    i_sum = {1'b0, i_addr} + OFF_EXT;
    i_oob = (i_sum >= DEPTH_EXT);
    d_oob = ({1'b0, d_addr} >= DEPTH_EXT);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    contend      = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    mem_r_en     = 1'b0;
    mem_w_en     = 1'b0;
    mem_iord     = IORD_INSTR;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        contend = i_req && d_req;
        if (gnt[0]) begin
          owner_d      = OWN_I;
          last_grant_d = OWN_I;
          addr_d       = i_addr;
          we_d         = 1'b0;
          err_d        = i_oob;
          state_d      = ACCESS;
        end else if (gnt[1]) begin
          owner_d      = OWN_D;
          last_grant_d = OWN_D;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
          err_d        = d_oob;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        contend   = (owner_q == OWN_I) ? d_req : i_req;
        mem_iord  = (owner_q == OWN_I) ? IORD_INSTR : IORD_DATA;
        mem_addr  = addr_q;
        mem_r_en  = !err_q && !we_q;
        mem_w_en  = !err_q && we_q;
        mem_wdata = (!err_q && we_q) ? wdata_q : '0;
        rdata_d   = (err_q || we_q) ? '0 : mem_rdata;
        state_d   = DONE;
      end
      DONE: begin
        contend = (owner_q == OWN_I) ? d_req : i_req;
        i_ready = (owner_q == OWN_I);
        d_ready = (owner_q == OWN_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cnt_d = contend ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Address/write data are only observed while gated by ACCESS, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign i_rdata        = i_ready ? rdata_q : '0;
  assign d_rdata        = d_ready ? rdata_q : '0;
  assign i_err          = i_ready && err_q;
  assign d_err          = d_ready && err_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 65-word memory model (fetches offset by 8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ready, i_err, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_r_en, mem_w_en, mem_iord;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] contention_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_word [65];
  logic        written  [65];
  int          midx;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(65), .IF_OFFSET(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_iord(mem_iord),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as A000_0000 + index.
  always_comb begin
    midx = int'(mem_addr) + (mem_iord ? 0 : 8);
    if (mem_addr < 32'd65 && midx < 65)
      mem_rdata = written[midx] ? mem_word[midx] : (32'hA000_0000 + 32'(midx));
    else
      mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_w_en && mem_addr < 32'd65 && midx < 65) begin
      mem_word[midx] <= mem_wdata;
      written[midx]  <= 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 65; k++) written[k] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input bit is_d, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input bit exp_err);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    step();
    check({tag, "_acc_ren"}, {31'd0, mem_r_en}, {31'd0, !exp_err && !we});
    check({tag, "_acc_wen"}, {31'd0, mem_w_en}, {31'd0, !exp_err && we});
    check({tag, "_acc_rdy"}, {30'd0, i_ready, d_ready}, 32'd0);
    if (!exp_err) begin
      check({tag, "_acc_addr"}, mem_addr, addr);
      check({tag, "_acc_iord"}, {31'd0, mem_iord}, {31'd0, is_d});
    end
    if (we && !exp_err) check({tag, "_acc_wdata"}, mem_wdata, wdata);
    step();
    check({tag, "_done_en"}, {30'd0, mem_r_en, mem_w_en}, 32'd0);
    if (is_d) begin
      check({tag, "_done_rdy"}, {30'd0, i_ready, d_ready}, 32'd1);
      check({tag, "_done_rdata"}, d_rdata, exp_rd);
      check({tag, "_done_err"}, {31'd0, d_err}, {31'd0, exp_err});
    end else begin
      check({tag, "_done_rdy"}, {30'd0, i_ready, d_ready}, 32'd2);
      check({tag, "_done_rdata"}, i_rdata, exp_rd);
      check({tag, "_done_err"}, {31'd0, i_err}, {31'd0, exp_err});
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    check({tag, "_idle_rdy"}, {30'd0, i_ready, d_ready}, 32'd0);
  endtask

  initial begin
    int prev, alt_bad, both_bad, ngrant;

    repeat (3) step();
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check("rst_err", {30'd0, i_err, d_err}, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    check("rst_mem_en", {29'd0, mem_r_en, mem_w_en, mem_iord}, 32'd0);
    check("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
    check("rst_cnt", {16'd0, contention_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    xact("fetch3", 1'b0, 1'b0, 32'd3, 32'd0, 32'hA000_000B, 1'b0);
    check("fetch_cnt", {16'd0, contention_cnt}, 32'd0);
    xact("store5", 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    xact("load5", 1'b1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Tie right after reset: fetch first, data at the following IDLE.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    i_req = 1'b1; i_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    step();
    check("tie_acc1_iord", {31'd0, mem_iord}, 32'd0);
    check("tie_acc1_addr", mem_addr, 32'd1);
    step();
    check("tie_done1_rdy", {30'd0, i_ready, d_ready}, 32'd2);
    check("tie_done1_rdata", i_rdata, 32'hA000_0009);
    check("tie_done1_cnt", {16'd0, contention_cnt}, 32'd2);
    i_req = 1'b0;
    step();
    check("tie_idle_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    step();
    check("tie_acc2_iord", {31'd0, mem_iord}, 32'd1);
    check("tie_acc2_addr", mem_addr, 32'd2);
    check("tie_acc2_ren", {31'd0, mem_r_en}, 32'd1);
    step();
    check("tie_done2_rdy", {30'd0, i_ready, d_ready}, 32'd1);
    check("tie_done2_rdata", d_rdata, 32'hA000_0002);
    check("tie_done2_cnt", {16'd0, contention_cnt}, 32'd3);
    d_req = 1'b0;
    step();

    xact("ferr60", 1'b0, 1'b0, 32'd60, 32'd0, 32'd0, 1'b1);
    xact("fok56", 1'b0, 1'b0, 32'd56, 32'd0, 32'hA000_0040, 1'b0);
    xact("dok64", 1'b1, 1'b0, 32'd64, 32'd0, 32'hA000_0040, 1'b0);
    xact("derr65", 1'b1, 1'b0, 32'd65, 32'd0, 32'd0, 1'b1);
    xact("ferrbig", 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
    xact("dstore_err", 1'b1, 1'b1, 32'd70, 32'h1111_2222, 32'd0, 1'b1);
    check("pre_rst_cnt", {16'd0, contention_cnt}, 32'd3);

    // Reset in the middle of a store's ACCESS cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h1234_5678;
    step();
    check("mid_acc_wen", {31'd0, mem_w_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wen", {30'd0, mem_w_en, mem_r_en}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("mid_rst_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    rst_n = 1'b1;
    check("mid_rst_cnt", {16'd0, contention_cnt}, 32'd0);
    step();
    check("post_rst_idle_en", {29'd0, mem_r_en, mem_w_en, mem_iord}, 32'd0);
    step();
    check("post_rst_rdy", {30'd0, i_ready, d_ready}, 32'd0);
    xact("load7", 1'b1, 1'b0, 32'd7, 32'd0, 32'hA000_0007, 1'b0);

    // Both requests held continuously long enough to saturate the counter.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd0;
    prev = 1; alt_bad = 0; both_bad = 0; ngrant = 0;
    for (int k = 0; k < 65600; k++) begin
      step();
      if (i_ready && d_ready) begin
        both_bad++;
      end else if (i_ready) begin
        if (prev == 0) alt_bad++;
        prev = 0;
        ngrant++;
      end else if (d_ready) begin
        if (prev == 1) alt_bad++;
        prev = 1;
        ngrant++;
      end
    end
    check("sat_cnt", {16'd0, contention_cnt}, 32'h0000_FFFF);
    check("sat_alternate", alt_bad, 32'd0);
    check("sat_both_ready", both_bad, 32'd0);
    check("sat_grants", {31'd0, ngrant >= 21800}, 32'd1);
    repeat (10) step();
    check("sat_hold", {16'd0, contention_cnt}, 32'h0000_FFFF);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
